cr_cnt_mc: RTL
==============

# cr_cnt_mc

Multi-channel, parametrised credit counter with a built-in round-robin start arbiter. Each channel has its own signed credit counter. A transaction start reserves a full burst of credits. The actual-length report returns the unused part of the reservation, and each output-FIFO read returns one credit. The block sits between the per-channel RAM1 readers and the shared output FIFOs, and it grants at most one transaction start per clock.

## Interface
- N_CH, 4: number of channels, 1..16.
- CH_W, 2: width of the channel index, $clog2(N_CH) with a minimum of 1.
- CNT_W, 8: width of each signed credit counter.
- LEN_W, 4: width of the length report.
- MAX_BURST, 15: credits reserved by every transaction start; must be below 2^LEN_W.
- INIT_CREDIT, 32: reset value and ceiling of each counter; must be below 2^(CNT_W-1).
- ALLOW_NEG, 0: 0 selects strict mode, 1 selects legacy mode (see enable rule).

Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset_p, in, 1: reset. One clock domain; reset is asynchronous and active-high.
- req, in, N_CH: per-channel transaction request, held high until granted.
- grant, out, N_CH: one-hot, one-cycle pulse; marks the transaction start for that channel.
- transaction_enable, out, N_CH: 1 means the channel may be granted.
- len_vld, in, 1: 1 means len_ch/len are valid.
- len_ch, in, CH_W: channel that the length report refers to.
- len, in, LEN_W: actual number of words read for one transaction.
- fifo_rd_en, in, N_CH: per-channel FIFO read; returns 1 credit.
- credit_cnt, out, N_CH*CNT_W: counters, flattened; channel i occupies bits [i*CNT_W +: CNT_W]; two's complement.
- err, out, N_CH: sticky per-channel error flag.
- err_clr, in, 1: clears all err bits.

## Operation
- Per-channel delta each cycle is the sum of three terms, computed in CNT_W+2 bits, signed:
  - −MAX_BURST if the channel is granted this edge.
  - +(MAX_BURST − len) if len_vld and len_ch equals the channel.
  - +1 if fifo_rd_en for the channel.
- Length error: if len > MAX_BURST, the return term is 0 and the channel's err bit is set.
- Next counter value is cnt + delta with clamping:
  - Above INIT_CREDIT: load INIT_CREDIT and set err.
  - Below −2^(CNT_W−1): load −2^(CNT_W−1) and set err.
- transaction_enable[i] is combinational from the registered counter:
  - Strict mode (ALLOW_NEG=0): cnt ≥ MAX_BURST, so a counter never goes negative through grants.
  - Legacy mode (ALLOW_NEG=1): cnt ≥ 0, i.e. the sign bit is clear.
- Eligible channel: req[i] & transaction_enable[i] & ~grant[i]. A channel is never granted in two consecutive cycles.
- Arbiter is round-robin:
  - The search starts at pointer ptr and wraps modulo N_CH.
  - The first eligible channel wins.
  - ptr is updated to winner+1 (mod N_CH) only when a grant is issued.
- Requester rule: req must drop no later than the cycle after grant is seen; otherwise a second transaction is started.
- err: set by length or clamp errors. err_clr has priority over a set in the same cycle, and the set event is lost.
- len_ch ≥ N_CH with len_vld: ignored, no error.

## Timing
- Asynchronous reset_p assertion, effective immediately and including mid-operation:
  - Every counter is INIT_CREDIT.
  - grant = 0, err = 0, ptr = 0.
  - transaction_enable = all-ones if INIT_CREDIT ≥ MAX_BURST (strict mode) or ≥ 0 (legacy mode).
- After reset release, the first grant is possible on the first edge.
- Arbitration decision in cycle t:
  - grant is registered high in cycle t+1.
  - The counter decrement lands on the same edge, so credit_cnt and transaction_enable reflect the start in cycle t+1.
- Length return and FIFO read: registered, latency 1 cycle.
- Simultaneous grant, length report and read on one channel are applied in one edge as a single sum; no event is dropped.
- grant output has no combinational path from req, because the arbiter result is registered.

## Test plan
Defaults, strict mode unless noted.
- Reset → credit_cnt = 32 for all channels; grant = 0; err = 0; transaction_enable = 4'b1111.
- Single channel:
  - ch0 requests continuously → grants issued with at least one idle cycle between them; counter goes 32→17→2; enable[0] drops at 2.
  - Then len_vld, len_ch=0, len=4 → counter 13.
  - Then two fifo_rd_en[0] pulses → counter 15 and enable[0]=1.
- All four channels request continuously → grant order 0,1,2,3,0,… until each channel reaches 2; no channel is skipped while eligible.
- ch1 at 17: grant, len_vld (len_ch=1, len=3) and fifo_rd_en[1] in the same cycle → 17−15+12+1 = 15.
- Error paths:
  - From reset, fifo_rd_en[2] for one cycle → counter stays 32 and err[2]=1.
  - err_clr → err[2]=0.
  - len=15 returns 0 with no error.
- Legacy mode (ALLOW_NEG=1) → ch0 counter goes 32→17→2→−13 (credit_cnt = 8'hF3); enable[0]=0 after the third grant.
- reset_p asserted mid-burst, between clock edges → outputs take reset values before the next edge.

Source files
------------

// File: rtl/cr_cnt_mc.sv
// Multi-channel signed credit counter with a registered round-robin start arbiter.
// A start reserves a full burst; length reports and FIFO reads hand credits back.
module cr_cnt_mc #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned MAX_BURST   = 15,
    parameter int unsigned INIT_CREDIT = 32,
    parameter bit          ALLOW_NEG   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_p,
    input  logic [N_CH-1:0]         req,
    output logic [N_CH-1:0]         grant,
    output logic [N_CH-1:0]         transaction_enable,
    input  logic                    len_vld,
    input  logic [CH_W-1:0]         len_ch,
    input  logic [LEN_W-1:0]        len,
    input  logic [N_CH-1:0]         fifo_rd_en,
    output logic [N_CH*CNT_W-1:0]   credit_cnt,
    output logic [N_CH-1:0]         err,
    input  logic                    err_clr
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(INIT_CREDIT);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(-(2 ** (CNT_W - 1)));
    localparam logic signed [SUM_W-1:0] BURST   = SUM_W'(MAX_BURST);

    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;
    logic [CH_W-1:0]            ptr;
    logic [CH_W-1:0]            ptr_d;
    logic [CH_W-1:0]            idx;
    logic [N_CH-1:0]            eligible;
    logic [N_CH-1:0]            grant_d;
    logic [N_CH-1:0]            err_set;
    logic [N_CH-1:0]            err_d;
    logic                       win_found;
    logic signed [SUM_W-1:0]    sum;

    // Start permission straight from the registered counter
    always_comb begin
        transaction_enable = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ALLOW_NEG)
                transaction_enable[i] = ~cnt_q[i][CNT_W-1];
            else
                transaction_enable[i] = SUM_W'($signed(cnt_q[i])) >= BURST;
        end
    end

    // Round-robin search from ptr; a channel granted last cycle sits this one out
    always_comb begin
        eligible  = req & transaction_enable & ~grant;
        win_found = 1'b0;
        grant_d   = '0;
        ptr_d     = ptr;
        idx       = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = CH_W'((32'(ptr) + k) % N_CH);
            if (!win_found && eligible[idx]) begin
                win_found    = 1'b1;
                grant_d[idx] = 1'b1;
                ptr_d        = CH_W'((32'(idx) + 1) % N_CH);
            end
        end
    end

    // Grant, length return and read fold into one saturating sum per channel
    always_comb begin
        cnt_d   = cnt_q;
        err_set = '0;
        sum     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            sum = SUM_W'($signed(cnt_q[i]));
            if (grant_d[i])
                sum = sum - BURST;
            if (len_vld && (32'(len_ch) == i)) begin
                if (32'(len) > MAX_BURST)
                    err_set[i] = 1'b1;
                else
                    sum = sum + BURST - SUM_W'(len);
            end
            if (fifo_rd_en[i])
                sum = sum + SUM_W'(1);
            if (sum > SUM_MAX) begin
                cnt_d[i]   = CNT_W'(SUM_MAX);
                err_set[i] = 1'b1;
            end else if (sum < SUM_MIN) begin
                cnt_d[i]   = CNT_W'(SUM_MIN);
                err_set[i] = 1'b1;
            end else begin
                cnt_d[i]   = CNT_W'(sum);
            end
        end
        err_d = err_clr ? '0 : (err | err_set);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int unsigned i = 0; i < N_CH; i++)
                cnt_q[i] <= CNT_W'(INIT_CREDIT);
            grant <= '0;
            err   <= '0;
            ptr   <= '0;
        end else begin
            cnt_q <= cnt_d;
            grant <= grant_d;
            err   <= err_d;
            ptr   <= ptr_d;
        end
    end

    assign credit_cnt = cnt_q;

endmodule
